bit_index_decoder: RTL

BIT_INDEX_DECODER -- requirements
Module: bit_index_decoder

---
 rtl/bit_index_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bit_index_decoder.sv
// bit_index_decoder: rebuilds an N-bit word from a stream of set-bit indices
// that arrive highest-first. The word is held in HOLD until out_ready.
// Optional ordering/duplicate checking is built when BIT_INDEX_ERR_CHECK_EN
// is defined; this adds the out_err port and the last-index tracking flops.
//
// Handshake: an input beat transfers only in a cycle where in_valid and
// in_ready are both 1. An output word transfers in a cycle where out_valid
// and out_ready are both 1. out_valid/out_word/out_count (and out_err) hold
// steady until that transfer happens.
module bit_index_decoder #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_idx,
  input  logic          in_nil,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_word,
  output logic [IW:0]   out_count,
`ifdef BIT_INDEX_ERR_CHECK_EN
  output logic          out_err,
`endif
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic [IW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;
  logic          idx_ok;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign idx_ok    = (int'(in_idx) < N);
  assign out_valid = out_valid_q;
  assign out_word  = out_valid_q ? word_q : '0;
  assign out_count = out_valid_q ? count_q : '0;
  assign dbg_state = state_q;

  // Next-state, word and count update for accepted beats and HOLD release
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (!in_nil && idx_ok && !word_q[in_idx]) begin
            word_d[in_idx] = 1'b1;
            count_d        = count_q + (IW+1)'(1);
          end
          state_d = in_last ? HOLD : COLLECT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          word_d  = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
        count_d = '0;
      end
    endcase
    out_valid_d = (state_d == HOLD);
  end

  // State, word, count and registered out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BIT_INDEX_ERR_CHECK_EN
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic          have_idx_q, have_idx_d;
  logic          err_q, err_d;

  assign out_err = out_valid_q ? err_q : 1'b0;

  // Track the previous non-nil index of the message; flag non-descending order
  always_comb begin
    last_idx_d = last_idx_q;
    have_idx_d = have_idx_q;
    err_d      = err_q;
    if (accept && !in_nil) begin
      if (have_idx_q && (in_idx >= last_idx_q)) begin
        err_d = 1'b1;
      end
      last_idx_d = in_idx;
      have_idx_d = 1'b1;
    end else if ((state_q == HOLD) && out_ready) begin
      last_idx_d = '0;
      have_idx_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  // Error-tracking registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_idx_q <= '0;
      have_idx_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_idx_q <= last_idx_d;
      have_idx_q <= have_idx_d;
      err_q      <= err_d;
    end
  end
`endif

endmodule
